// File: rtl/mem_sram_seq.sv
// Sequencer that moves one 36-bit PDP-10 word to/from an asynchronous SRAM
// as BEATS narrow accesses, each framed by SETUP / STROBE / HOLD.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | controls released, bus Z, waiting for mem_read / mem_write
// SETUP  | chip selected, address (and write data) settling
// STROBE | OE_n or WE_n asserted for WAIT+1 cycles; read samples at end
// HOLD   | strobe released, address/data held; next beat or DONE
// DONE   | mem_ack while request stays high; wait for request to drop
module mem_sram_seq #(
    parameter int ADDR_W  = 18,
    parameter int BEAT_W  = 9,
    parameter int SRAM_DW = 16,
    parameter int WAIT    = 0,
    localparam int BEATS   = 36 / BEAT_W,
    localparam int BEAT_AW = $clog2(BEATS),
    localparam int SRAM_AW = 1 + ADDR_W + BEAT_AW
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_user,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [35:0]        mem_write_data,
    output logic [35:0]        mem_read_data,
    output logic               mem_ack,
    output logic [SRAM_AW-1:0] sram_addr,
    inout  wire  [SRAM_DW-1:0] sram_dq,
    output logic               CE_n,
    output logic               OE_n,
    output logic               WE_n,
    output logic               UB_n,
    output logic               LB_n
);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

    state_t               state, state_nxt;
    logic [ADDR_W-1:0]    addr_q;
    logic                 user_q;
    logic                 wr_q;
    logic                 dropped_q;
    logic [35:0]          wdata_q;
    logic [BEAT_AW-1:0]   beat_q, beat_nxt;
    logic [2:0]           wait_q, wait_nxt;
    logic                 req;
    logic                 accept;
    logic                 rd_sample;
    logic                 dq_oe;
    logic [SRAM_DW-1:0]   dq_out;
    logic [BEAT_W-1:0]    wr_beat [BEATS];
    logic                 dq_unused;

    assign req       = mem_read | mem_write;
    assign sram_addr = {user_q, addr_q, beat_q};
    assign sram_dq   = dq_oe ? dq_out : 'z;
    assign dq_unused = ^sram_dq;

    // Beat k carries PDP bits k*BEAT_W.. (bit 0 = MSB), so beat 0 is the top slice.
    for (genvar k = 0; k < BEATS; k++) begin : g_beat
        assign wr_beat[k] = wdata_q[35-k*BEAT_W -: BEAT_W];
    end

    always_comb begin
        dq_out             = '0;
        dq_out[BEAT_W-1:0] = wr_beat[beat_q];
    end

    always_comb begin
        state_nxt = state;
        beat_nxt  = beat_q;
        wait_nxt  = wait_q;
        accept    = 1'b0;
        rd_sample = 1'b0;
        dq_oe     = 1'b0;
        mem_ack   = 1'b0;
        CE_n      = 1'b1;
        OE_n      = 1'b1;
        WE_n      = 1'b1;
        UB_n      = 1'b1;
        LB_n      = 1'b1;
        case (state)
            IDLE: begin
                if (req) begin
                    accept    = 1'b1;
                    beat_nxt  = '0;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                CE_n      = 1'b0;
                UB_n      = 1'b0;
                LB_n      = 1'b0;
                dq_oe     = wr_q;
                wait_nxt  = 3'(WAIT);
                state_nxt = STROBE;
            end
            STROBE: begin
                CE_n  = 1'b0;
                UB_n  = 1'b0;
                LB_n  = 1'b0;
                dq_oe = wr_q;
                OE_n  = wr_q;
                WE_n  = ~wr_q;
                if (wait_q == 3'd0) begin
                    rd_sample = ~wr_q;
                    state_nxt = HOLD;
                end else begin
                    wait_nxt = wait_q - 3'd1;
                end
            end
            HOLD: begin
                CE_n  = 1'b0;
                UB_n  = 1'b0;
                LB_n  = 1'b0;
                dq_oe = wr_q;
                if (beat_q == BEAT_AW'(BEATS - 1)) begin
                    state_nxt = DONE;
                end else begin
                    beat_nxt  = beat_q + 1'b1;
                    state_nxt = SETUP;
                end
            end
            DONE: begin
                mem_ack = ~dropped_q;
                if (!req) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            beat_q    <= '0;
            wait_q    <= '0;
            addr_q    <= '0;
            user_q    <= 1'b0;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            dropped_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            beat_q <= beat_nxt;
            wait_q <= wait_nxt;
            if (accept) begin
                addr_q    <= mem_addr;
                user_q    <= mem_user;
                wr_q      <= mem_write;
                wdata_q   <= mem_write_data;
                dropped_q <= 1'b0;
            end else if ((state inside {SETUP, STROBE, HOLD}) && !req) begin
                // An abandoned request still runs to completion but never acks.
                dropped_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_read_data <= '0;
        end else if (rd_sample) begin
            for (int k = 0; k < BEATS; k++) begin
                if (beat_q == BEAT_AW'(k))
                    mem_read_data[35-k*BEAT_W -: BEAT_W] <= sram_dq[BEAT_W-1:0];
            end
        end
    end

endmodule

// File: doc/mem_sram_seq.md
MEM_SRAM_SEQ -- requirements
Module: mem_sram_seq

Interface
REQ-001 Parameter ADDR_W, 18, width of processor word address.
REQ-002 Parameter BEAT_W, 9, word bits moved per SRAM access; legal values 9 or 18; BEATS = 36/BEAT_W (4 or 2).
REQ-003 Parameter SRAM_DW, 16, SRAM data bus width; legal 16 or 18; BEAT_W <= SRAM_DW.
REQ-004 Parameter WAIT, 0, extra strobe cycles per beat; legal 0..7.
REQ-005 Derived SRAM_AW = 1 + ADDR_W + log2(BEATS).
REQ-006 clk  in  1  single clock; all state changes on its rising edge.
REQ-007 reset_n  in  1  reset; asynchronous, active-low.
REQ-008 mem_addr  in  ADDR_W  word address, sampled at request acceptance.
REQ-009 mem_user  in  1  user/exec space select, sampled at acceptance.
REQ-010 mem_read, mem_write  in  1 each  level request strobes.
REQ-011 mem_write_data  in  36  write word, PDP-10 order (bit 0 = MSB), sampled at acceptance.
REQ-012 mem_read_data  out  36  assembled read word, same order.
REQ-013 mem_ack  out  1  transaction complete.
REQ-014 sram_addr  out  SRAM_AW  = {user, addr, beat}.
REQ-015 sram_dq  inout  SRAM_DW  SRAM data bus.
REQ-016 CE_n, OE_n, WE_n, UB_n, LB_n  out  1 each  active-low SRAM controls.

Function
REQ-017 FSM states: IDLE, SETUP, STROBE, HOLD, DONE.
REQ-018 IDLE: all SRAM controls high, sram_dq Z; on mem_write or mem_read, latch addr/user/data/op, beat=0, go SETUP; if both high, write wins.
REQ-019 SETUP (1 cycle): CE_n=UB_n=LB_n=0, OE_n=WE_n=1, sram_addr valid; write drives beat data; go STROBE with wait counter=WAIT.
REQ-020 STROBE (WAIT+1 cycles): read asserts OE_n=0, write asserts WE_n=0; counter decrements; at counter 0 read samples sram_dq[BEAT_W-1:0] into slot, go HOLD.
REQ-021 HOLD (1 cycle): OE_n=WE_n=1, CE_n stays 0, address and write data held; if beat=BEATS-1 go DONE, else beat+1, go SETUP.
REQ-022 Beat k carries word bits [k*BEAT_W .. k*BEAT_W+BEAT_W-1] (PDP order) on sram_dq[BEAT_W-1:0]; on write, sram_dq bits above BEAT_W-1 driven 0.
REQ-023 sram_dq driven only in SETUP/STROBE/HOLD of a write; Z otherwise.
REQ-024 DONE: CE_n=UB_n=LB_n=1; mem_ack=1 while request remains high; request low -> mem_ack=0 next edge, go IDLE.
REQ-025 Request dropped before DONE: sequence completes all beats, no ack pulse, return IDLE.
REQ-026 Latency request-seen-to-ack: BEATS*(WAIT+3)+1 cycles for both read and write.
REQ-027 mem_read_data updates only by read beats; holds last read word otherwise.
REQ-028 New request not accepted until FSM back in IDLE with both requests sampled low at least one cycle after DONE.

Reset
REQ-029 reset_n low: immediately state=IDLE, CE_n=OE_n=WE_n=UB_n=LB_n=1, sram_dq Z, mem_ack=0, beat=0, mem_read_data=0.
REQ-030 Reset mid-transaction aborts without further SRAM strobes; no ack after release until a new request.

Verification
REQ-031 BEAT_W=9, WAIT=0, write 36'o123456701234 to addr 5 exec -> four WE pulses at sram_addr {0,5,0..3}, dq 9'o123,9'o456,9'o701,9'o234; ack at cycle 13.
REQ-032 Read back same location -> mem_read_data=36'o123456701234, OE pulse per beat, ack at cycle 13, sram_dq never driven.
REQ-033 BEAT_W=18, SRAM_DW=18, WAIT=3 read -> 2 beats, OE_n low 4 cycles each, ack at cycle 13.
REQ-034 mem_read and mem_write both high -> write performed, ack once; user=1 sets sram_addr MSB.
REQ-035 reset_n low during STROBE of beat 2 -> controls high and dq Z same cycle; no ack; next read completes normally.
REQ-036 Request dropped in beat 1 -> remaining beats run, ack never asserts, IDLE reached after full latency.
